uart_hex_parser: RTL and testbench
==================================

Name: uart_hex_parser

Overview:
Downstream consumer of the UART receiver in the HEX calculator. It takes received ASCII bytes (byte plus one-cycle valid strobe) and parses one command of the form `<hexA><op><hexB><term>`. It emits both binary operands and an opcode to the calculator core over a valid/ready handshake. Malformed input is reported with an error pulse and a sticky error code.

Parameters:
DW, 16, operand width in bits; must be a multiple of 4.
MAX_DIG, DW/4, maximum hex digits accepted per operand.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
rx_data  input  8  received ASCII byte from the UART receiver.
rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
cmd_ready  input  1  calculator core accepts the command.
op_a  output  DW  operand A, binary.
op_b  output  DW  operand B, binary.
op_code  output  2  operator: 00 '+', 01 '-', 10 '*', 11 '/'.
cmd_valid  output  1  command available; held until accepted.
parse_err  output  1  one-cycle error pulse.
err_code  output  2  code of the last error; sticky.

Behaviour:
- Reset and clock: asynchronous active-low reset (n_rst) on a single clock (clk).
- Reset values: all outputs 0; state IDLE; digit counter 0. Reset mid-command discards the partial command.
- Byte classes:
  - Hex digit: '0'-'9', 'A'-'F', 'a'-'f'. Case-insensitive, converted to a 4-bit nibble.
  - Operators: '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F.
  - Terminators: '=' 0x3D, CR 0x0D.
  - Space 0x20: ignored in IDLE, OPA and OPB.
  - ESC 0x1B: in IDLE, OPA or OPB, silently clears accumulators and returns to IDLE with no error.
- Bytes are processed only in cycles where rx_valid=1.
- Accumulate rule: acc <= {acc[DW-5:0], nibble}; cnt <= cnt+1.
- IDLE:
  - hex -> acc_a=nibble, cnt=1, go to OPA.
  - Any other non-ignored byte -> error BADCHAR.
- OPA:
  - hex with cnt<MAX_DIG -> accumulate.
  - hex with cnt==MAX_DIG -> error OVERFLOW.
  - operator -> latch opcode, cnt=0, acc_b=0, go to OPB.
  - terminator or other byte -> error BADCHAR.
- OPB:
  - hex -> accumulate under the same OVERFLOW rule.
  - terminator with cnt>=1 -> go to HOLD.
  - terminator with cnt==0 -> error EMPTY.
  - operator or other byte -> error BADCHAR.
- HOLD:
  - cmd_valid=1. op_a, op_b and op_code are registered and stable while cmd_valid is high.
  - cmd_ready=1 -> cmd_valid deasserts on the next edge; go to IDLE.
  - rx_valid while cmd_ready=0 -> byte dropped, error OVERRUN; stay in HOLD; cmd_valid and fields unchanged. ESC has no effect in HOLD.
  - rx_valid and cmd_ready in the same cycle -> command accepted, and the byte is processed with IDLE rules in that same cycle. No byte is lost.
- Latency: cmd_valid rises on the clock edge following the terminator's rx_valid cycle.
- Error action:
  - parse_err=1 for exactly one cycle.
  - err_code <= code: 00 BADCHAR, 01 OVERFLOW, 10 EMPTY, 11 OVERRUN.
  - Except for OVERRUN: accumulators and cnt are cleared and the state returns to IDLE. The offending byte is not re-parsed.
  - err_code holds until the next error or reset.
- Output values: op_a and op_b are zero-extended when fewer than MAX_DIG digits are given. They keep their values after acceptance until the next command loads them.
- No back-pressure toward the receiver. Every rx_valid byte is consumed or dropped in its own cycle.

Decomposition:
- Package uart_hex_pkg holds:
  - ASCII constants: operators, '=', CR, space, ESC.
  - Opcode encodings.
  - Error code encodings.
  - Parser state encoding (IDLE, OPA, OPB, HOLD).
- One sub-module, hex_ascii_decode: combinational, 8-bit ASCII in -> is_hex, 4-bit nibble, is_op, 2-bit opcode, is_term.

Test Plan:
1. "1A+2f=" with cmd_ready=1 -> one-cycle cmd_valid, op_a=0x001A, op_b=0x002F, op_code=00, no parse_err.
2. "12345" -> parse_err on the 5th byte with err_code=01; the next "3*4\r" yields op_a=0x0003, op_b=0x0004, op_code=10.
3. "7*=" -> parse_err on '=' with err_code=10, state returns to IDLE; "G" from IDLE -> err_code=00.
4. "FFFF/1=" with cmd_ready=0, then send 'A' -> parse_err with err_code=11; cmd_valid stays 1 with op_a=0xFFFF, op_b=0x0001, op_code=11. Raise cmd_ready -> cmd_valid drops after one cycle.
5. While in HOLD, drive cmd_ready=1 and rx_valid with '5' in the same cycle; follow with "-1=" -> second command op_a=0x0005, op_b=0x0001, op_code=01.
6. "12+3" then ESC, then "4-2=" -> first command discarded with no error; op_a=0x0004, op_b=0x0002. Repeat "12+3" then pulse n_rst low -> all outputs 0 and state IDLE.

Source files
------------

// File: rtl/uart_hex_pkg.sv
// Shared constants and encodings for the UART HEX command parser:
// ASCII codes for operators, terminators, space and ESC; opcode and
// error-code encodings; parser state encoding.
package uart_hex_pkg;

  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_STAR  = 8'h2A;
  localparam logic [7:0] ASC_SLASH = 8'h2F;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_ESC   = 8'h1B;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_BADCHAR  = 2'b00,
    ERR_OVERFLOW = 2'b01,
    ERR_EMPTY    = 2'b10,
    ERR_OVERRUN  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OPA  = 2'b01,
    ST_OPB  = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

endpackage

// File: rtl/uart_hex_parser_decode.sv
// hex_ascii_decode: combinational ASCII byte classifier.
//   rx_data  in  : ASCII byte
//   is_hex   out : byte is 0-9, A-F or a-f
//   nibble   out : 4-bit value of the hex digit (0 when not hex)
//   is_op    out : byte is + - * /
//   op_code  out : operator encoding (0 when not an operator)
//   is_term  out : byte is '=' or CR
module hex_ascii_decode
  import uart_hex_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_op,
  output logic [1:0] op_code,
  output logic       is_term
);

  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them to 10.
      is_hex = 1'b1;
      nibble = rx_data[3:0] + 4'd9;
    end
  end

  always_comb begin
    is_op   = 1'b1;
    op_code = OP_ADD;
    case (rx_data)
      ASC_PLUS:  op_code = OP_ADD;
      ASC_MINUS: op_code = OP_SUB;
      ASC_STAR:  op_code = OP_MUL;
      ASC_SLASH: op_code = OP_DIV;
      default:   is_op   = 1'b0;
    endcase
  end

  assign is_term = (rx_data == ASC_EQ) || (rx_data == ASC_CR);

endmodule

// File: rtl/uart_hex_parser.sv
// uart_hex_parser: parses "<hexA><op><hexB><term>" from UART bytes and
// presents the operands and opcode to the calculator core on a
// valid/ready handshake. Malformed input gives a one-cycle parse_err and
// a sticky err_code.
//   clk, n_rst           clock, async active-low reset
//   rx_data, rx_valid    received byte and its one-cycle strobe
//   cmd_ready            core accepts the command
//   op_a, op_b, op_code  command fields, stable while cmd_valid
//   cmd_valid            command available, held until accepted
//   parse_err, err_code  error pulse and last error code
//
// state   | meaning
// ST_IDLE | waiting for first digit of operand A
// ST_OPA  | collecting operand A digits, waiting for operator
// ST_OPB  | collecting operand B digits, waiting for terminator
// ST_HOLD | command presented, waiting for cmd_ready
module uart_hex_parser
  import uart_hex_pkg::*;
#(
  parameter int DW      = 16,
  parameter int MAX_DIG = DW / 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          cmd_ready,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [1:0]    op_code,
  output logic          cmd_valid,
  output logic          parse_err,
  output logic [1:0]    err_code
);

  localparam int CW = $clog2(MAX_DIG + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIG);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_q, state_d, eff_state;
  logic [DW-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    opc_q, opc_d;
  logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]    op_code_q, op_code_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          parse_err_q, parse_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          is_hex, is_op, is_term;
  logic [3:0]    nibble;
  logic [1:0]    dec_op;
  logic          err_set;
  err_e          err_val;

  hex_ascii_decode u_dec (
    .rx_data (rx_data),
    .is_hex  (is_hex),
    .nibble  (nibble),
    .is_op   (is_op),
    .op_code (dec_op),
    .is_term (is_term)
  );

  always_comb begin
    state_d     = state_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    cnt_d       = cnt_q;
    opc_d       = opc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_code_d   = op_code_q;
    cmd_valid_d = cmd_valid_q;
    parse_err_d = 1'b0;
    err_code_d  = err_code_q;
    err_set     = 1'b0;
    err_val     = ERR_BADCHAR;
    eff_state   = state_q;

    // Acceptance and a same-cycle byte: the byte is parsed as if in IDLE.
    if (state_q == ST_HOLD && cmd_ready) begin
      eff_state   = ST_IDLE;
      state_d     = ST_IDLE;
      cmd_valid_d = 1'b0;
    end

    if (rx_valid) begin
      if (eff_state != ST_HOLD && rx_data == ASC_ESC) begin
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else if (eff_state != ST_HOLD && rx_data == ASC_SPACE) begin
        // ignored
      end else begin
        case (eff_state)
          ST_IDLE: begin
            if (is_hex) begin
              acc_a_d = {{(DW-4){1'b0}}, nibble};
              cnt_d   = CNT_ONE;
              state_d = ST_OPA;
            end else begin
              err_set = 1'b1;
            end
          end
          ST_OPA: begin
            if (is_hex) begin
              if (cnt_q < CNT_MAX) begin
                acc_a_d = {acc_a_q[DW-5:0], nibble};
                cnt_d   = cnt_q + CNT_ONE;
              end else begin
                err_set = 1'b1;
                err_val = ERR_OVERFLOW;
              end
            end else if (is_op) begin
              opc_d   = dec_op;
              cnt_d   = '0;
              acc_b_d = '0;
              state_d = ST_OPB;
            end else begin
              err_set = 1'b1;
            end
          end
          ST_OPB: begin
            if (is_hex) begin
              if (cnt_q < CNT_MAX) begin
                acc_b_d = {acc_b_q[DW-5:0], nibble};
                cnt_d   = cnt_q + CNT_ONE;
              end else begin
                err_set = 1'b1;
                err_val = ERR_OVERFLOW;
              end
            end else if (is_term) begin
              if (cnt_q != '0) begin
                op_a_d      = acc_a_q;
                op_b_d      = acc_b_q;
                op_code_d   = opc_q;
                cmd_valid_d = 1'b1;
                state_d     = ST_HOLD;
              end else begin
                err_set = 1'b1;
                err_val = ERR_EMPTY;
              end
            end else begin
              err_set = 1'b1;
            end
          end
          default: begin
            // HOLD without acceptance: byte is dropped.
            err_set = 1'b1;
            err_val = ERR_OVERRUN;
          end
        endcase
      end
    end

    if (err_set) begin
      parse_err_d = 1'b1;
      err_code_d  = err_val;
      if (err_val != ERR_OVERRUN) begin
        acc_a_d = '0;
        acc_b_d = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      cnt_q       <= '0;
      opc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= '0;
      cmd_valid_q <= 1'b0;
      parse_err_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      cnt_q       <= cnt_d;
      opc_q       <= opc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_code_q   <= op_code_d;
      cmd_valid_q <= cmd_valid_d;
      parse_err_q <= parse_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_code   = op_code_q;
  assign cmd_valid = cmd_valid_q;
  assign parse_err = parse_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_hex_parser.sv
// Testbench for uart_hex_parser: directed command sequences followed by
// random byte traffic, all checked against a text-level reference model
// that keeps the current partial command as a queue of characters.
module tb_uart_hex_parser;

  localparam int DW   = 16;
  localparam int MAXD = DW / 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          cmd_ready = 1'b0;
  logic [DW-1:0] op_a, op_b;
  logic [1:0]    op_code, err_code;
  logic          cmd_valid, parse_err;

  int n_tests = 0;
  int n_fail  = 0;

  uart_hex_parser #(.DW(DW), .MAX_DIG(MAXD)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cmd_ready (cmd_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_code   (op_code),
    .cmd_valid (cmd_valid),
    .parse_err (parse_err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]    txt[$];
  bit            m_hold, m_valid, m_err;
  logic [1:0]    m_code, m_op;
  logic [DW-1:0] m_a, m_b;

  function automatic bit c_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int c_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 65 + 10;
    return int'(c) - 97 + 10;
  endfunction

  function automatic bit c_op(input logic [7:0] c);
    return c == "+" || c == "-" || c == "*" || c == "/";
  endfunction

  function automatic logic [1:0] c_opv(input logic [7:0] c);
    case (c)
      "+": return 2'd0;
      "-": return 2'd1;
      "*": return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic bit c_term(input logic [7:0] c);
    return c == "=" || c == 8'h0D;
  endfunction

  task automatic m_raise(input logic [1:0] c);
    m_err  = 1'b1;
    m_code = c;
    if (c != 2'd3) txt.delete();
  endtask

  task automatic m_complete(input int opi);
    int a, b;
    a = 0;
    b = 0;
    for (int i = 0; i < opi; i++) a = a * 16 + c_val(txt[i]);
    for (int i = opi + 1; i < txt.size(); i++) b = b * 16 + c_val(txt[i]);
    m_a     = DW'(a);
    m_b     = DW'(b);
    m_op    = c_opv(txt[opi]);
    m_valid = 1'b1;
    m_hold  = 1'b1;
    txt.delete();
  endtask

  task automatic m_reset();
    txt.delete();
    m_hold = 0; m_valid = 0; m_err = 0;
    m_code = 0; m_op = 0; m_a = 0; m_b = 0;
  endtask

  task automatic m_step(input bit v, input logic [7:0] d, input bit rdy);
    bit proc;
    int opi, nb;
    m_err = 1'b0;
    proc  = v;
    if (m_hold) begin
      if (rdy) begin
        m_hold  = 0;
        m_valid = 0;
      end else begin
        if (v) m_raise(2'd3);
        proc = 0;
      end
    end
    if (proc && d != 8'h1B && d != 8'h20) begin
      opi = -1;
      foreach (txt[i]) if (c_op(txt[i])) opi = i;
      if (txt.size() == 0) begin
        if (c_hex(d)) txt.push_back(d);
        else m_raise(2'd0);
      end else if (opi < 0) begin
        if (c_hex(d)) begin
          if (txt.size() == MAXD) m_raise(2'd1);
          else txt.push_back(d);
        end else if (c_op(d)) txt.push_back(d);
        else m_raise(2'd0);
      end else begin
        nb = txt.size() - opi - 1;
        if (c_hex(d)) begin
          if (nb == MAXD) m_raise(2'd1);
          else txt.push_back(d);
        end else if (c_term(d)) begin
          if (nb == 0) m_raise(2'd2);
          else m_complete(opi);
        end else m_raise(2'd0);
      end
    end else if (proc && d == 8'h1B) begin
      txt.delete();
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    check("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    check("parse_err", 32'(parse_err), 32'(m_err));
    check("err_code",  32'(err_code),  32'(m_code));
    check("op_a",      32'(op_a),      32'(m_a));
    check("op_b",      32'(op_b),      32'(m_b));
    check("op_code",   32'(op_code),   32'(m_op));
  endtask

  // Called at a negedge; drives one cycle and checks after the next posedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
    rx_valid  = v;
    rx_data   = d;
    cmd_ready = rdy;
    m_step(v, d, rdy);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    check_model();
  endtask

  task automatic send(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], rdy);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_err"},   32'(parse_err), 32'd0);
    check({tag, "_code"},  32'(err_code),  32'd0);
    check({tag, "_a"},     32'(op_a),      32'd0);
    check({tag, "_b"},     32'(op_b),      32'd0);
    check({tag, "_op"},    32'(op_code),   32'd0);
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check_zero("rst");
    n_rst = 1'b1;
    @(negedge clk);

    // 1: basic command, ready held high
    send("1A+2f=", 1'b1);
    check("t1_valid", 32'(cmd_valid), 32'd1);
    check("t1_a", 32'(op_a), 32'h001A);
    check("t1_b", 32'(op_b), 32'h002F);
    check("t1_op", 32'(op_code), 32'd0);
    cycle(1'b0, 8'h00, 1'b1);
    check("t1_drop", 32'(cmd_valid), 32'd0);

    // 2: overflow on fifth digit, then recovery
    send("12345", 1'b1);
    check("t2_err", 32'(parse_err), 32'd1);
    check("t2_code", 32'(err_code), 32'd1);
    send("3*4\r", 1'b0);
    check("t2_a", 32'(op_a), 32'h0003);
    check("t2_b", 32'(op_b), 32'h0004);
    check("t2_op", 32'(op_code), 32'd2);
    cycle(1'b0, 8'h00, 1'b1);

    // 3: empty operand B, then bad char from IDLE
    send("7*=", 1'b0);
    check("t3_code", 32'(err_code), 32'd2);
    send("G", 1'b0);
    check("t3_bad", 32'(err_code), 32'd0);

    // 4: overrun while holding
    send("FFFF/1=", 1'b0);
    send("A", 1'b0);
    check("t4_err", 32'(parse_err), 32'd1);
    check("t4_code", 32'(err_code), 32'd3);
    check("t4_valid", 32'(cmd_valid), 32'd1);
    check("t4_a", 32'(op_a), 32'hFFFF);
    check("t4_b", 32'(op_b), 32'h0001);
    check("t4_op", 32'(op_code), 32'd3);
    cycle(1'b0, 8'h00, 1'b1);
    check("t4_drop", 32'(cmd_valid), 32'd0);

    // 5: accept and new byte in the same cycle
    send("9+9=", 1'b0);
    cycle(1'b1, "5", 1'b1);
    send("-1=", 1'b0);
    check("t5_a", 32'(op_a), 32'h0005);
    check("t5_b", 32'(op_b), 32'h0001);
    check("t5_op", 32'(op_code), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // 6: ESC discard, then reset mid-command
    send("12+3", 1'b0);
    cycle(1'b1, 8'h1B, 1'b0);
    check("t6_esc_err", 32'(parse_err), 32'd0);
    send("4-2=", 1'b0);
    check("t6_a", 32'(op_a), 32'h0004);
    check("t6_b", 32'(op_b), 32'h0002);
    cycle(1'b0, 8'h00, 1'b1);
    send("12+3", 1'b0);
    n_rst = 1'b0;
    m_reset();
    @(negedge clk);
    check_zero("t6_rst");
    n_rst = 1'b1;
    @(negedge clk);
    send("8/2=", 1'b0);
    check("t6_after_a", 32'(op_a), 32'h0008);
    cycle(1'b0, 8'h00, 1'b1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 45) begin
        r = int'($urandom_range(0, 21));
        b = (r < 10) ? 8'(48 + r) : (r < 16) ? 8'(65 + r - 10) : 8'(97 + r - 16);
      end else if (r < 60) begin
        r = int'($urandom_range(0, 3));
        b = (r == 0) ? "+" : (r == 1) ? "-" : (r == 2) ? "*" : "/";
      end else if (r < 72) b = ($urandom_range(0, 1) == 0) ? "=" : 8'h0D;
      else if (r < 78) b = 8'h20;
      else if (r < 81) b = 8'h1B;
      else b = 8'($urandom);
      cycle($urandom_range(0, 3) != 0, b, $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
